// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch / PC stage.
//   - fetch_state_e : fetch sequencer states
//   - NOP_INSTR     : decoder no-op opcode, shown on instruction_o after reset
//   - BR_OFFSET     : branch distance table indexed by instruction[2:0]
//   - br_offset()   : table lookup helper
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALTED  = 3'd4
  } fetch_state_e;

  localparam logic [7:0] NOP_INSTR = 8'b10111000;

  // Widest entry is 16, so 5 bits hold every offset.
  localparam int unsigned BR_OFF_W = 5;
  typedef logic [BR_OFF_W-1:0] br_off_t;

  localparam br_off_t BR_OFFSET [8] = '{
    5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd8, 5'd12, 5'd16
  };

  function automatic br_off_t br_offset(input logic [2:0] sel);
    return BR_OFFSET[sel];
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection for the RESOLVE cycle.
// Priority done > branch-forward > branch-back > sequential. Offsets are
// unsigned, zero-extended to PC_W; all arithmetic wraps modulo 2^PC_W.
// Ports:
//   pc_i       current PC
//   sel_i      offset table index (instruction[2:0])
//   done_i     halt request
//   branchf_i  forward branch request
//   branchb_i  backward branch request
//   next_pc_o  selected next PC (equals pc_i when halting)
//   halt_o     halt selected
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [2:0]      sel_i,
  input  logic            done_i,
  input  logic            branchf_i,
  input  logic            branchb_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            halt_o
);

  logic [PC_W-1:0] offset;

  always_comb begin
    offset = PC_W'(br_offset(sel_i));
    halt_o = done_i;
    if (done_i) begin
      next_pc_o = pc_i;
    end else if (branchf_i) begin
      next_pc_o = pc_i + offset;
    end else if (branchb_i) begin
      next_pc_o = pc_i - offset;
    end else begin
      next_pc_o = pc_i + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and program-counter stage.
// Each instruction slot is REQ -> ISSUE -> RESOLVE (3 cycles). The ROM is
// registered, so data for imem_addr_o is latched in ISSUE; the control unit's
// registered branch/done outputs are sampled in RESOLVE.
// Optional feature: define FETCH_INSTR_CNT_EN to enable the saturating
// retired-instruction counter; otherwise instr_count_o is tied to 0.
// Ports:
//   clock_i, reset_i   clock, synchronous active-high reset
//   start_i            start pulse (accepted in IDLE/HALTED)
//   start_addr_i       first PC of the program
//   imem_addr_o        instruction ROM address (registered)
//   imem_data_i        ROM data for the previous cycle's address
//   instruction_o      instruction to the control unit (registered)
//   instr_valid_o      one-cycle pulse when instruction_o is new
//   branchf_i          branch-forward request (valid in RESOLVE)
//   branchb_i          branch-back request (valid in RESOLVE)
//   done_i             halt request (valid in RESOLVE)
//   pc_o               PC of presented / resolving instruction
//   halted_o           high while halted
//   instr_count_o      retired-instruction count
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [7:0]       imem_data_i,
  output logic [7:0]       instruction_o,
  output logic             instr_valid_o,
  input  logic             branchf_i,
  input  logic             branchb_i,
  input  logic             done_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_count_o
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] addr_q;
  logic [7:0]      instr_q;
  logic            valid_q;
  logic            halted_q;
  logic [2:0]      sel_q;

  logic [PC_W-1:0] next_pc_d;
  logic            halt_d;
  logic            start_ok;

  // start_i is only honoured while no slot is in flight.
  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_HALTED));

  fetch_next_pc #(
    .PC_W(PC_W)
  ) u_next_pc (
    .pc_i      (pc_q),
    .sel_i     (sel_q),
    .done_i    (done_i),
    .branchf_i (branchf_i),
    .branchb_i (branchb_i),
    .next_pc_o (next_pc_d),
    .halt_o    (halt_d)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start_ok) begin
            pc_q     <= start_addr_i;
            addr_q   <= start_addr_i;
            halted_q <= 1'b0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          instr_q <= imem_data_i;
          sel_q   <= imem_data_i[2:0];
          valid_q <= 1'b1;
          state_q <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (halt_d) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            pc_q    <= next_pc_d;
            addr_q  <= next_pc_d;
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr_o   = addr_q;
  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign halted_o      = halted_q;

`ifdef FETCH_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts every RESOLVE, including the halting one; saturates at all-ones.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if ((state_q == ST_RESOLVE) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_count_o = cnt_q;
`else
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: bench-side ROM, table-driven control-unit
// responder, slot-level behavioural model with a per-cycle compare, and
// directed literal checks taken from worked examples.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic [PC_W-1:0]  start_addr_i;
  logic [PC_W-1:0]  imem_addr_o;
  logic [7:0]       imem_data_i;
  logic [7:0]       instruction_o;
  logic             instr_valid_o;
  logic             branchf_i;
  logic             branchb_i;
  logic             done_i;
  logic [PC_W-1:0]  pc_o;
  logic             halted_o;
  logic [CNT_W-1:0] instr_count_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock_i       (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .start_addr_i  (start_addr_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .instruction_o (instruction_o),
    .instr_valid_o (instr_valid_o),
    .branchf_i     (branchf_i),
    .branchb_i     (branchb_i),
    .done_i        (done_i),
    .pc_o          (pc_o),
    .halted_o      (halted_o),
    .instr_count_o (instr_count_o)
  );

  // Program: ROM contents plus per-PC control-unit answers.
  logic [7:0] rom    [DEPTH];
  bit         bf_tab [DEPTH];
  bit         bb_tab [DEPTH];
  bit         dn_tab [DEPTH];
  int         offs   [8] = '{1, 2, 3, 4, 6, 8, 12, 16};

  always @(posedge clk) imem_data_i <= rom[imem_addr_o];

  // Control unit: answers for the presented instruction stay stable through
  // the cycle after the pulse; at all other times it drives random noise.
  bit jf, jb, jd;
  always @(posedge clk) begin
    jf <= ($urandom_range(0, 1) == 1);
    jb <= ($urandom_range(0, 1) == 1);
    jd <= ($urandom_range(0, 1) == 1);
  end
  assign branchf_i = instr_valid_o ? bf_tab[pc_o] : jf;
  assign branchb_i = instr_valid_o ? bb_tab[pc_o] : jb;
  assign done_i    = instr_valid_o ? dn_tab[pc_o] : jd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef enum {M_IDLE, M_RUN, M_HALT} mmode_e;
  mmode_e mode;
  int exp_pc, exp_addr, exp_instr, exp_cnt, age;
  bit exp_valid, exp_halt, chk_en;

  initial begin
    int off;
    mode = M_IDLE; exp_pc = 0; exp_addr = 0; exp_instr = 8'hB8; exp_cnt = 0;
    age = 0; exp_valid = 0; exp_halt = 0; chk_en = 0;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        mode = M_IDLE; exp_pc = 0; exp_addr = 0; exp_instr = 8'hB8;
        exp_cnt = 0; exp_valid = 0; exp_halt = 0; chk_en = 1;
      end else if (mode != M_RUN) begin
        exp_valid = 0;
        if (start_i) begin
          mode = M_RUN; exp_pc = int'(start_addr_i); exp_addr = exp_pc;
          exp_cnt = 0; exp_halt = 0; age = 0;
        end
      end else begin
        exp_valid = 0;
        if (age == 0) begin
          age = 1;
        end else if (age == 1) begin
          age = 2; exp_valid = 1; exp_instr = int'(rom[exp_pc]);
        end else begin
          if (exp_cnt < CNT_MAX) exp_cnt++;
          off = offs[rom[exp_pc] & 8'h07];
          if (dn_tab[exp_pc]) begin
            mode = M_HALT; exp_halt = 1;
          end else begin
            if (bf_tab[exp_pc])      exp_pc = (exp_pc + off) % DEPTH;
            else if (bb_tab[exp_pc]) exp_pc = (exp_pc + DEPTH - off) % DEPTH;
            else                     exp_pc = (exp_pc + 1) % DEPTH;
            exp_addr = exp_pc; age = 0;
          end
        end
      end
      @(negedge clk);
      if (chk_en) begin
        check("m_addr",   int'(imem_addr_o),   exp_addr);
        check("m_pc",     int'(pc_o),          exp_pc);
        check("m_valid",  int'(instr_valid_o), int'(exp_valid));
        check("m_instr",  int'(instruction_o), exp_instr);
        check("m_halted", int'(halted_o),      int'(exp_halt));
`ifdef FETCH_INSTR_CNT_EN
        check("m_count",  int'(instr_count_o), exp_cnt);
`else
        check("m_count",  int'(instr_count_o), 0);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = 8'hB8; bf_tab[i] = 0; bb_tab[i] = 0; dn_tab[i] = 0;
    end
  endtask

  // Returns 1 ns after the edge that accepted the start.
  task automatic do_start(input int addr);
    @(negedge clk);
    start_i = 1'b1;
    start_addr_i = PC_W'(addr);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(halted_o), 1);
  endtask

  task automatic after_slot_addr(input string name, input int exp);
    repeat (3) @(posedge clk);
    #1;
    check(name, int'(imem_addr_o), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; start_addr_i = '0;
    clear_prog();
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",   int'(imem_addr_o),   0);
    check("rst_pc",     int'(pc_o),          0);
    check("rst_instr",  int'(instruction_o), 8'hB8);
    check("rst_valid",  int'(instr_valid_o), 0);
    check("rst_halted", int'(halted_o),      0);
    check("rst_count",  int'(instr_count_o), 0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(posedge clk);

    // Sequential run from 0; a start pulse mid-run must be ignored.
    dn_tab[3] = 1;
    do_start(0);
    check("seq_addr0", int'(imem_addr_o), 0);
    after_slot_addr("seq_addr1", 1);
    after_slot_addr("seq_addr2", 2);
    after_slot_addr("seq_addr3", 3);
    @(negedge clk);
    start_i = 1'b1; start_addr_i = 10'd77;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_halted("seq_halt", 40);
    check("seq_halt_pc", int'(pc_o), 3);

    // Forward branch: pc 5, sel 3 -> 9.
    clear_prog();
    rom[5] = 8'hBB; bf_tab[5] = 1; dn_tab[9] = 1;
    do_start(5);
    after_slot_addr("fwd_addr", 9);
    wait_halted("fwd_halt", 40);

    // Backward branch: pc 20, sel 7 -> 4.
    clear_prog();
    rom[20] = 8'hBF; bb_tab[20] = 1; dn_tab[4] = 1;
    do_start(20);
    after_slot_addr("bwd_addr", 4);
    wait_halted("bwd_halt", 40);

    // Both branches: forward wins. pc 100, sel 2 -> 103.
    clear_prog();
    rom[100] = 8'hBA; bf_tab[100] = 1; bb_tab[100] = 1; dn_tab[103] = 1;
    do_start(100);
    after_slot_addr("both_addr", 103);
    wait_halted("both_halt", 40);

    // Wrap-around both directions.
    clear_prog();
    rom[1020] = 8'hBF; bf_tab[1020] = 1; dn_tab[12] = 1;
    rom[2] = 8'hBD; bb_tab[2] = 1; dn_tab[1018] = 1;
    do_start(1020);
    after_slot_addr("wrap_fwd_addr", 12);
    wait_halted("wrap_fwd_halt", 40);
    do_start(2);
    after_slot_addr("wrap_bwd_addr", 1018);
    wait_halted("wrap_bwd_halt", 40);

    // Priority: done with both branches -> halt, pc unchanged; restart at 40.
    clear_prog();
    dn_tab[50] = 1; bf_tab[50] = 1; bb_tab[50] = 1;
    rom[40] = 8'h5A; dn_tab[40] = 1;
    do_start(50);
    wait_halted("prio_halt", 40);
    check("prio_pc", int'(pc_o), 50);
    do_start(40);
    check("restart_addr",   int'(imem_addr_o), 40);
    check("restart_halted", int'(halted_o),    0);
    wait_halted("restart_halt", 40);
    check("restart_instr", int'(instruction_o), 8'h5A);

    // Reset during ISSUE.
    rom[60] = 8'h77;
    do_start(60);
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("mrst_instr", int'(instruction_o), 8'hB8);
    check("mrst_valid", int'(instr_valid_o), 0);
    check("mrst_count", int'(instr_count_o), 0);
    check("mrst_addr",  int'(imem_addr_o),   0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (2) @(posedge clk);

    // Counter: 20 instructions with a 4-bit counter.
    clear_prog();
    dn_tab[219] = 1;
    do_start(200);
    wait_halted("cnt_halt", 200);
`ifdef FETCH_INSTR_CNT_EN
    check("cnt_sat", int'(instr_count_o), 15);
`else
    check("cnt_off", int'(instr_count_o), 0);
`endif
    check("cnt_pc", int'(pc_o), 219);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
